// File: rtl/ping_responder_if.sv
// Signal bundle between a PING host-side harness (master) and the sensor emulator (slave).
// There is no valid/ready handshake: enable/dist_cm are levels, sig_in is the raw line, trig_err is a 1-cycle pulse.
interface ping_responder_if;
  logic        enable;
  logic [12:0] dist_cm;
  logic        sig_in;
  logic        sig_out;
  logic        sig_oe;
  logic        busy;
  logic        trig_err;
  logic [2:0]  dbg_state;

  modport slave (
    input  enable, dist_cm, sig_in,
    output sig_out, sig_oe, busy, trig_err, dbg_state
  );

  modport master (
    output enable, dist_cm, sig_in,
    input  sig_out, sig_oe, busy, trig_err, dbg_state
  );
endinterface

// File: rtl/ping_responder.sv
// Sensor-side emulation of the single-wire ultrasonic PING protocol: validates the host
// trigger, holds the line low for the hold-off, then drives an echo whose width encodes distance.
module ping_responder #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned US_PER_CM   = 58,
  parameter int unsigned TRIG_MIN_US = 2,
  parameter int unsigned TRIG_MAX_US = 10,
  parameter int unsigned HOLDOFF_US  = 750,
  parameter int unsigned NOECHO_US   = 18500,
  parameter int unsigned DIST_MIN_CM = 2,
  parameter int unsigned DIST_MAX_CM = 318,
  parameter int unsigned RECOVER_US  = 200
) (
  input  logic            CLK,
  input  logic            RESET_N,
  ping_responder_if.slave bus
);

  localparam int unsigned CYC = CLK_HZ / 1_000_000;

  localparam logic [23:0] TRIG_MIN_C   = 24'(TRIG_MIN_US * CYC);
  localparam logic [23:0] TRIG_MAX_C   = 24'(TRIG_MAX_US * CYC);
  localparam logic [23:0] HOLDOFF_LAST = 24'(HOLDOFF_US * CYC - 1);
  localparam logic [23:0] RECOVER_LAST = 24'(RECOVER_US * CYC - 1);
  localparam logic [23:0] NOECHO_LEN   = 24'(NOECHO_US * CYC);
  localparam logic [23:0] ECHO_PER_CM  = 24'(US_PER_CM * CYC);
  localparam logic [12:0] DIST_MIN     = 13'(DIST_MIN_CM);
  localparam logic [12:0] DIST_MAX     = 13'(DIST_MAX_CM);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TRIG    = 3'd1,
    S_WAITLOW = 3'd2,
    S_HOLDOFF = 3'd3,
    S_ECHO    = 3'd4,
    S_RECOVER = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_err;
  logic        w_count_en;

  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync_d;
  logic        w_rise;
  logic        w_fall;

  logic [23:0] r_cnt;
  logic [23:0] w_width;
  logic [12:0] r_dist;
  logic [12:0] w_clamped;
  logic [23:0] w_len;
  logic [23:0] r_len;
  logic        r_trig_err;

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync1  <= bus.sig_in;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  assign w_rise  = r_sync2 & ~r_sync_d;
  assign w_fall  = ~r_sync2 & r_sync_d;
  // The counter holds (cycles seen high - 1) while in TRIG, so the measured width is cnt+1.
  assign w_width = r_cnt + 24'd1;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_err      = 1'b0;
    w_count_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise && bus.enable) w_next = S_TRIG;
      end
      S_TRIG: begin
        w_count_en = r_sync2;
        if (w_fall) begin
          if (w_width >= TRIG_MIN_C && w_width <= TRIG_MAX_C) begin
            w_next = S_HOLDOFF;
          end else begin
            w_next = S_IDLE;
            w_err  = 1'b1;
          end
        end else if (r_sync2 && r_cnt == TRIG_MAX_C) begin
          w_next = S_WAITLOW;
          w_err  = 1'b1;
        end
      end
      S_WAITLOW: begin
        if (!r_sync2) w_next = S_IDLE;
      end
      S_HOLDOFF: begin
        w_count_en = 1'b1;
        if (r_cnt == HOLDOFF_LAST) w_next = S_ECHO;
      end
      S_ECHO: begin
        w_count_en = 1'b1;
        if (r_cnt == r_len - 24'd1) w_next = S_RECOVER;
      end
      S_RECOVER: begin
        w_count_en = 1'b1;
        if (r_cnt == RECOVER_LAST) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.sig_oe    = 1'b0;
    bus.sig_out   = 1'b0;
    bus.busy      = (r_state != S_IDLE);
    bus.trig_err  = r_trig_err;
    bus.dbg_state = r_state;
    case (r_state)
      S_HOLDOFF: bus.sig_oe = 1'b1;
      S_ECHO: begin
        bus.sig_oe  = 1'b1;
        bus.sig_out = 1'b1;
      end
      default: ;
    endcase
  end

  // Zero distance means "no object" and gets the fixed long echo instead of the clamp.
  always_comb begin
    w_clamped = r_dist;
    if (r_dist < DIST_MIN)      w_clamped = DIST_MIN;
    else if (r_dist > DIST_MAX) w_clamped = DIST_MAX;
    w_len = (r_dist == 13'd0) ? NOECHO_LEN : 24'(w_clamped) * ECHO_PER_CM;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt      <= 24'd0;
      r_dist     <= 13'd0;
      r_len      <= 24'd0;
      r_trig_err <= 1'b0;
    end else begin
      r_trig_err <= w_err;
      if (r_state != w_next)  r_cnt <= 24'd0;
      else if (w_count_en)    r_cnt <= r_cnt + 24'd1;
      if (r_state == S_TRIG && w_next == S_HOLDOFF) r_dist <= bus.dist_cm;
      if (r_state == S_HOLDOFF)                     r_len  <= w_len;
    end
  end

endmodule

// File: tb/tb_ping_responder.sv
// Bench for ping_responder at a 1 MHz clock (one cycle per microsecond) so echo widths stay short.
module tb_ping_responder;

  logic clk = 1'b0;
  logic rst_n;
  logic host_sig;

  always #5 clk = ~clk;

  ping_responder_if bus();

  // The shared line: the responder reads back its own drive while sig_oe is high.
  assign bus.sig_in = bus.sig_oe ? bus.sig_out : host_sig;

  ping_responder #(.CLK_HZ(1_000_000)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  localparam logic [23:0] ERR_TOKEN = 24'hFFFFFF;

  logic [23:0] exp_q[$];
  int n_vec     = 0;
  int n_err     = 0;
  int n_oe_rise = 0;

  logic        prev_oe;
  logic        prev_echo;
  logic        cur_echo;
  logic [23:0] exp_v;
  int          hold_cnt;
  int          echo_cnt;
  int          rec_cnt;
  bit          rec_active;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
  endtask

  // Monitor: measures each hold-off/echo/recover interval and trig_err pulse, pops the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_oe    = 1'b0;
      prev_echo  = 1'b0;
      hold_cnt   = 0;
      echo_cnt   = 0;
      rec_cnt    = 0;
      rec_active = 1'b0;
    end else begin
      cur_echo = bus.sig_oe && bus.sig_out;
      if (bus.trig_err) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL trig_err_unexpected: got pulse, required none");
        end else begin
          exp_v = exp_q.pop_front();
          check("trig_err_event", int'(ERR_TOKEN), int'(exp_v));
        end
      end
      if (bus.sig_oe && !prev_oe) begin
        n_oe_rise++;
        hold_cnt = 0;
        echo_cnt = 0;
      end
      if (bus.sig_oe && !bus.sig_out) hold_cnt++;
      if (cur_echo) echo_cnt++;
      if (rec_active) begin
        if (bus.busy) rec_cnt++;
        else begin
          check("recover_len", rec_cnt, 200);
          rec_active = 1'b0;
        end
      end
      if (prev_echo && !cur_echo) begin
        check("holdoff_len", hold_cnt, 750);
        check("oe_after_echo", int'(bus.sig_oe), 0);
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL echo_unexpected: got echo of %0d, required none", echo_cnt);
        end else begin
          exp_v = exp_q.pop_front();
          check("echo_len", echo_cnt, int'(exp_v));
        end
        rec_active = 1'b1;
        rec_cnt    = 1;
      end
      prev_oe   = bus.sig_oe;
      prev_echo = cur_echo;
    end
  end

  task automatic trig(input int w);
    @(negedge clk);
    host_sig = 1'b1;
    repeat (w) @(negedge clk);
    host_sig = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    repeat (4) @(negedge clk);
    while (bus.busy && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) fail_now("idle_timeout");
  endtask

  task automatic wait_echo(input int max_cycles);
    int n = 0;
    while (!(bus.sig_oe && bus.sig_out) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (!(bus.sig_oe && bus.sig_out)) fail_now("echo_start_timeout");
  endtask

  initial begin
    #900_000;
    fail_now("global_watchdog");
    summary();
    $finish;
  end

  initial begin
    int lat;
    int base;
    int n;
    rst_n       = 1'b0;
    host_sig    = 1'b0;
    bus.enable  = 1'b0;
    bus.dist_cm = 13'd0;
    repeat (3) @(negedge clk);
    check("rst_sig_oe",   int'(bus.sig_oe),    0);
    check("rst_sig_out",  int'(bus.sig_out),   0);
    check("rst_busy",     int'(bus.busy),      0);
    check("rst_trig_err", int'(bus.trig_err),  0);
    check("rst_state",    int'(bus.dbg_state), 0);
    rst_n      = 1'b1;
    bus.enable = 1'b1;
    repeat (3) @(negedge clk);

    // Nominal 100 cm: 5800-cycle echo, hold-off starts 2-3 cycles after the trigger falls.
    bus.dist_cm = 13'd100;
    exp_q.push_back(24'd5800);
    trig(5);
    lat = 0;
    while (!bus.sig_oe && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("oe_latency_2to3", int'(lat >= 2 && lat <= 3), 1);
    wait_idle(25000);

    bus.dist_cm = 13'd0;
    exp_q.push_back(24'd18500);
    trig(5);
    wait_idle(25000);
    bus.dist_cm = 13'd1;
    exp_q.push_back(24'd116);
    trig(5);
    wait_idle(25000);
    bus.dist_cm = 13'd1000;
    exp_q.push_back(24'd18444);
    trig(5);
    wait_idle(25000);

    // Out-of-range triggers: too short, then held past the maximum.
    base = n_oe_rise;
    exp_q.push_back(ERR_TOKEN);
    trig(1);
    wait_idle(100);
    exp_q.push_back(ERR_TOKEN);
    trig(15);
    wait_idle(100);
    check("no_echo_after_err", n_oe_rise, base);
    check("idle_after_err", int'(bus.dbg_state), 0);

    bus.enable = 1'b0;
    base = n_oe_rise;
    trig(5);
    repeat (20) @(negedge clk);
    check("disabled_no_oe", n_oe_rise, base);
    check("disabled_busy", int'(bus.busy), 0);
    bus.enable = 1'b1;

    bus.dist_cm = 13'd20;
    exp_q.push_back(24'd1160);
    trig(5);
    n = 0;
    while (!bus.sig_oe && n < 10) begin
      @(negedge clk);
      n++;
    end
    bus.dist_cm = 13'd30;
    wait_idle(25000);
    bus.dist_cm = 13'd20;

    // Trigger during recover is ignored; one shortly after recover is served.
    exp_q.push_back(24'd1160);
    trig(5);
    wait_echo(2000);
    n = 0;
    while (bus.sig_oe && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (50) @(negedge clk);
    base = n_oe_rise;
    trig(5);
    wait_idle(1000);
    check("recover_trig_ignored", n_oe_rise, base);
    @(negedge clk);
    exp_q.push_back(24'd1160);
    trig(5);
    wait_idle(25000);
    check("after_recover_served", n_oe_rise, base + 1);

    // Asynchronous reset in the middle of an echo.
    trig(5);
    wait_echo(2000);
    repeat (100) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_oe",   int'(bus.sig_oe),  0);
    check("async_rst_busy", int'(bus.busy),    0);
    check("async_rst_out",  int'(bus.sig_out), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.push_back(24'd1160);
    trig(5);
    wait_idle(25000);

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    summary();
    $finish;
  end

endmodule
